// File: rtl/nor_chain_stim_pkg.sv
// Shared types for the NOR-chain pulse-train stimulus generator.
// FSM state encoding and mode constants.
package nor_chain_stim_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_A1   = 2'b00;
    localparam logic [1:0] MODE_A2   = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_SKEW = 2'b11;

endpackage

// File: rtl/nor_chain_stim_if.sv
// Control/config/response bundle between test controller and the
// NOR-chain stimulus generator.
interface nor_chain_stim_if #(
    parameter int CNT_W    = 16,
    parameter int NUM_W    = 8,
    parameter int MAX_SKEW = 15
);
    localparam int SKW_W = $clog2(MAX_SKEW + 1);

    logic             start;
    logic [CNT_W-1:0] pulse_width;
    logic [CNT_W-1:0] gap_width;
    logic [NUM_W-1:0] pulse_count;
    logic [1:0]       mode;
    logic [SKW_W-1:0] skew;
    logic             z_in;
    logic             a1;
    logic             a2;
    logic             busy;
    logic             done;
    logic [15:0]      edge_count;

    modport master (
        output start, pulse_width, gap_width,
        output pulse_count, mode, skew, z_in,
        input  a1, a2, busy, done, edge_count
    );

    modport slave (
        input  start, pulse_width, gap_width,
        input  pulse_count, mode, skew, z_in,
        output a1, a2, busy, done, edge_count
    );

endinterface

// File: rtl/nor_chain_stim_skew_line.sv
// Delay line for the pulse source: shift register of past p values
// plus a tap mux; sel=0 passes p straight through.
module stim_skew_line #(
    parameter int DEPTH = 15,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             p_in,
    input  logic [SEL_W-1:0] sel,
    output logic             tap
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | DEPTH'(p_in);
        end
    end

    always_comb begin
        tap = p_in;
        for (int i = 1; i <= DEPTH; i++) begin
            if (sel == SEL_W'(i)) tap = sr[i-1];
        end
    end

endmodule

// File: rtl/nor_chain_stimulus_gen.sv
// Pulse-train generator driving NOR-chain inputs A1/A2.
// Optional z_in edge counter: `define NOR_CHAIN_STIM_EDGE_COUNT_EN
module nor_chain_stimulus_gen
    import nor_chain_stim_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int NUM_W    = 8,
    parameter int MAX_SKEW = 15
) (
    input logic             clk,
    input logic             rst,
    nor_chain_stim_if.slave bus
);

    localparam int SKW_W = $clog2(MAX_SKEW + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] wid_q, gap_q;
    logic [1:0]       mode_q;
    logic [SKW_W-1:0] skew_q;
    logic             a1_q, a2_q, busy_q, done_q;
    logic             a2_d, p, tap, accept;
    logic [CNT_W-1:0] pw_eff, gw_eff;
    logic [SKW_W-1:0] sk_eff;

    assign accept = (state_q == S_IDLE) && bus.start;
    assign p      = (state_q == S_PULSE);

    // Zero widths become one so the down-counters never wrap
    assign pw_eff = (bus.pulse_width == '0) ? CNT_W'(1)
                                            : bus.pulse_width;
    assign gw_eff = (bus.gap_width == '0) ? CNT_W'(1)
                                          : bus.gap_width;
    assign sk_eff = (bus.skew > SKW_W'(MAX_SKEW)) ? SKW_W'(MAX_SKEW)
                                                  : bus.skew;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            wid_q   <= CNT_W'(1);
            gap_q   <= CNT_W'(1);
            mode_q  <= MODE_A1;
            skew_q  <= '0;
            a1_q    <= 1'b0;
            a2_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            if (accept) begin
                wid_q  <= pw_eff;
                gap_q  <= gw_eff;
                mode_q <= bus.mode;
                skew_q <= sk_eff;
            end
            a1_q   <= p && (mode_q != MODE_A2);
            a2_q   <= a2_d;
            busy_q <= (state_q == S_PULSE) || (state_q == S_GAP)
                   || (state_q == S_DRAIN);
            done_q <= (state_q == S_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.pulse_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PULSE;
                        cnt_d   = pw_eff - CNT_W'(1);
                        rem_d   = bus.pulse_count;
                    end
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    rem_d = rem_q - NUM_W'(1);
                    if (rem_q != NUM_W'(1)) begin
                        state_d = S_GAP;
                        cnt_d   = gap_q - CNT_W'(1);
                    end else if (mode_q == MODE_SKEW && skew_q != '0) begin
                        state_d = S_DRAIN;
                        cnt_d   = CNT_W'(skew_q) - CNT_W'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = wid_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    stim_skew_line #(
        .DEPTH (MAX_SKEW),
        .SEL_W (SKW_W)
    ) u_skew (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .p_in (p),
        .sel  (skew_q),
        .tap  (tap)
    );

    always_comb begin
        a2_d = 1'b0;
        unique case (mode_q)
            MODE_A1:   a2_d = 1'b0;
            MODE_A2:   a2_d = p;
            MODE_BOTH: a2_d = p;
            MODE_SKEW: a2_d = tap;
            default:   a2_d = 1'b0;
        endcase
    end

    assign bus.a1   = a1_q;
    assign bus.a2   = a2_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef NOR_CHAIN_STIM_EDGE_COUNT_EN
    logic [2:0]  z_sync;
    logic [15:0] edge_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_sync <= '0;
            edge_q <= '0;
        end else begin
            z_sync <= {z_sync[1:0], bus.z_in};
            if (accept) begin
                edge_q <= '0;
            end else if (z_sync[1] && !z_sync[2]
                         && edge_q != 16'hFFFF) begin
                edge_q <= edge_q + 16'd1;
            end
        end
    end

    assign bus.edge_count = edge_q;
`else
    assign bus.edge_count = '0;
`endif

endmodule

// File: tb/tb_nor_chain_stimulus_gen.sv
// Directed testbench for nor_chain_stimulus_gen.
// Cycle k = value sampled 1 time unit after the k-th edge from start.
module tb_nor_chain_stimulus_gen;

    logic clk = 1'b0;
    logic rst;
    logic loop_en = 1'b0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    nor_chain_stim_if #(.CNT_W(16), .NUM_W(8), .MAX_SKEW(15)) bus ();

    nor_chain_stimulus_gen #(
        .CNT_W    (16),
        .NUM_W    (8),
        .MAX_SKEW (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.z_in = loop_en ? bus.a1 : 1'b0;

    logic [63:0] a1v, a2v, bv, dv;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic run_train(input int w, input int g, input int c,
                             input logic [1:0] m, input int s,
                             input int ncyc, input int hold);
        @(negedge clk);
        bus.pulse_width = 16'(w);
        bus.gap_width   = 16'(g);
        bus.pulse_count = 8'(c);
        bus.mode        = m;
        bus.skew        = 4'(s);
        bus.start       = 1'b1;
        a1v = '0; a2v = '0; bv = '0; dv = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            a1v[k] = bus.a1;
            a2v[k] = bus.a2;
            bv[k]  = bus.busy;
            dv[k]  = bus.done;
            if (k + 1 >= hold) begin
                bus.start = 1'b0;
            end else begin
                bus.pulse_width = 16'd7;
                bus.pulse_count = 8'd9;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.pulse_width = '0;
        bus.gap_width = '0;
        bus.pulse_count = '0;
        bus.mode = 2'b00;
        bus.skew = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.a1, bus.a2, bus.busy, bus.done} !== 4'b0000)
            $display("FAIL reset_outs got %b exp 0000",
                     {bus.a1, bus.a2, bus.busy, bus.done});
        else passed++;
        checks++;
        if (bus.edge_count !== 16'd0)
            $display("FAIL reset_edge got %0d exp 0", bus.edge_count);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mode_a1;
        run_train(3, 2, 2, 2'b00, 0, 14, 1);
        checks++;
        if (a1v !== (rng(1, 3) | rng(6, 8)))
            $display("FAIL a1only_a1 got %h exp %h", a1v,
                     rng(1, 3) | rng(6, 8));
        else passed++;
        checks++;
        if (a2v !== 64'd0)
            $display("FAIL a1only_a2 got %h exp 0", a2v);
        else passed++;
        checks++;
        if (bv !== rng(1, 8))
            $display("FAIL a1only_busy got %h exp %h", bv, rng(1, 8));
        else passed++;
        checks++;
        if (dv !== rng(9, 9))
            $display("FAIL a1only_done got %h exp %h", dv, rng(9, 9));
        else passed++;
    endtask

    task automatic test_skew;
        run_train(4, 4, 1, 2'b11, 2, 12, 1);
        checks++;
        if (a1v !== rng(1, 4))
            $display("FAIL skew_a1 got %h exp %h", a1v, rng(1, 4));
        else passed++;
        checks++;
        if (a2v !== rng(3, 6))
            $display("FAIL skew_a2 got %h exp %h", a2v, rng(3, 6));
        else passed++;
        checks++;
        if (bv !== rng(1, 6))
            $display("FAIL skew_busy got %h exp %h", bv, rng(1, 6));
        else passed++;
        checks++;
        if (dv !== rng(7, 7))
            $display("FAIL skew_done got %h exp %h", dv, rng(7, 7));
        else passed++;
    endtask

    task automatic test_max_skew;
        run_train(1, 1, 1, 2'b11, 15, 22, 1);
        checks++;
        if (a1v !== rng(1, 1) || a2v !== rng(16, 16))
            $display("FAIL maxskew_a got %h/%h exp %h/%h", a1v, a2v,
                     rng(1, 1), rng(16, 16));
        else passed++;
        checks++;
        if (dv !== rng(17, 17) || bv !== rng(1, 16))
            $display("FAIL maxskew_done got %h/%h exp %h/%h", dv, bv,
                     rng(17, 17), rng(1, 16));
        else passed++;
    endtask

    task automatic test_other_modes;
        run_train(2, 1, 2, 2'b01, 0, 10, 1);
        checks++;
        if (a1v !== 64'd0 || a2v !== (rng(1, 2) | rng(4, 5)))
            $display("FAIL a2only got %h/%h exp 0/%h", a1v, a2v,
                     rng(1, 2) | rng(4, 5));
        else passed++;
        checks++;
        if (dv !== rng(6, 6))
            $display("FAIL a2only_done got %h exp %h", dv, rng(6, 6));
        else passed++;
        run_train(1, 3, 2, 2'b10, 0, 10, 1);
        checks++;
        if (a1v !== (rng(1, 1) | rng(5, 5)) || a2v !== a1v)
            $display("FAIL both got %h/%h exp %h", a1v, a2v,
                     rng(1, 1) | rng(5, 5));
        else passed++;
        run_train(2, 2, 1, 2'b11, 0, 6, 1);
        checks++;
        if (a1v !== rng(1, 2) || a2v !== rng(1, 2) || dv !== rng(3, 3))
            $display("FAIL skew0 got %h/%h/%h exp %h/%h/%h", a1v, a2v,
                     dv, rng(1, 2), rng(1, 2), rng(3, 3));
        else passed++;
    endtask

    task automatic test_zero_width;
        run_train(0, 0, 3, 2'b00, 0, 9, 1);
        checks++;
        if (a1v !== (rng(1, 1) | rng(3, 3) | rng(5, 5)))
            $display("FAIL zerowid_a1 got %h exp %h", a1v,
                     rng(1, 1) | rng(3, 3) | rng(5, 5));
        else passed++;
        checks++;
        if (dv !== rng(6, 6))
            $display("FAIL zerowid_done got %h exp %h", dv, rng(6, 6));
        else passed++;
    endtask

    task automatic test_count_zero;
        run_train(3, 3, 0, 2'b10, 0, 5, 1);
        checks++;
        if (dv !== rng(1, 1))
            $display("FAIL cnt0_done got %h exp %h", dv, rng(1, 1));
        else passed++;
        checks++;
        if (a1v !== 64'd0 || a2v !== 64'd0 || bv !== 64'd0)
            $display("FAIL cnt0_outs got %h/%h/%h exp 0", a1v, a2v, bv);
        else passed++;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.pulse_width = 16'd5;
        bus.gap_width   = 16'd2;
        bus.pulse_count = 8'd3;
        bus.mode        = 2'b10;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.a1 !== 1'b1 || bus.a2 !== 1'b1)
            $display("FAIL midrst_pre got %b%b exp 11", bus.a1, bus.a2);
        else passed++;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.a1, bus.a2, bus.busy, bus.done} !== 4'b0000)
            $display("FAIL midrst_async got %b exp 0000",
                     {bus.a1, bus.a2, bus.busy, bus.done});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        run_train(2, 1, 1, 2'b00, 0, 6, 1);
        checks++;
        if (a1v !== rng(1, 2) || dv !== rng(3, 3) || bv !== rng(1, 2))
            $display("FAIL midrst_after got %h/%h/%h exp %h/%h/%h",
                     a1v, dv, bv, rng(1, 2), rng(3, 3), rng(1, 2));
        else passed++;
    endtask

    task automatic test_back_to_back;
        run_train(2, 2, 2, 2'b00, 0, 16, 5);
        checks++;
        if (a1v !== (rng(1, 2) | rng(5, 6)))
            $display("FAIL b2b_a1 got %h exp %h", a1v,
                     rng(1, 2) | rng(5, 6));
        else passed++;
        checks++;
        if (dv !== rng(7, 7))
            $display("FAIL b2b_done got %h exp %h", dv, rng(7, 7));
        else passed++;
    endtask

    task automatic test_edge_count;
        loop_en = 1'b1;
        run_train(2, 2, 5, 2'b00, 0, 25, 1);
        loop_en = 1'b0;
        checks++;
        if (dv !== rng(19, 19))
            $display("FAIL edge_done got %h exp %h", dv, rng(19, 19));
        else passed++;
`ifdef NOR_CHAIN_STIM_EDGE_COUNT_EN
        checks++;
        if (bus.edge_count !== 16'd5)
            $display("FAIL edge_count got %0d exp 5", bus.edge_count);
        else passed++;
`else
        checks++;
        if (bus.edge_count !== 16'd0)
            $display("FAIL edge_count got %0d exp 0", bus.edge_count);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_mode_a1();
        test_skew();
        test_max_skew();
        test_other_modes();
        test_zero_width();
        test_count_zero();
        test_reset_mid();
        test_back_to_back();
        test_edge_count();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
